// File: rtl/jtframe_rom_nslots_pkg.sv
// Shared definitions for the N-slot SDRAM ROM arbiter: width codes, FSM states
// and the client-to-SDRAM address mapping.
package jtframe_rom_nslots_pkg;

  localparam logic [1:0] SLOT_DW8  = 2'd0;
  localparam logic [1:0] SLOT_DW16 = 2'd1;
  localparam logic [1:0] SLOT_DW32 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } st_t;

  // SDRAM words are 16b: byte clients share a word, 32b clients span two.
  function automatic logic [21:0] map_addr(input logic [1:0] dw, input logic [21:0] off,
                                           input logic [31:0] addr);
    logic [31:0] w;
    case (dw)
      SLOT_DW8:  w = addr >> 1;
      SLOT_DW16: w = addr;
      default:   w = addr << 1;
    endcase
    return off + w[21:0];
  endfunction

endpackage

// File: rtl/jtframe_rom_nslots_cache.sv
// One-entry tag cache for a single ROM slot: hit detection, fill, clear and
// right-aligned output formatting for the slot's data width.
module jtframe_rom_nslots_cache
  import jtframe_rom_nslots_pkg::*;
#(
  parameter logic [1:0] DW = SLOT_DW32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] tag_i,
  input  logic        byte_i,
  input  logic        cs_i,
  input  logic        clr_i,
  input  logic        fill_i,
  input  logic [21:0] fill_tag_i,
  input  logic [31:0] fill_data_i,
  output logic        hit_o,
  output logic        ok_o,
  output logic [31:0] dout_o
);

  logic        valid_q;
  logic [21:0] tag_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_i) begin
        tag_q  <= fill_tag_i;
        data_q <= fill_data_i;
      end
      // a clear landing with a fill leaves the entry invalid
      if (clr_i)       valid_q <= 1'b0;
      else if (fill_i) valid_q <= 1'b1;
    end
  end

  assign hit_o = valid_q && (tag_q == tag_i);
  assign ok_o  = cs_i && hit_o;

  always_comb begin
    dout_o = '0;
    case (DW)
      SLOT_DW8:  dout_o[7:0]  = byte_i ? data_q[15:8] : data_q[7:0];
      SLOT_DW16: dout_o[15:0] = data_q[15:0];
      default:   dout_o       = data_q;
    endcase
  end

endmodule

// File: rtl/jtframe_rom_nslots.sv
// N-slot ROM read arbiter for one SDRAM bank. Define JTFRAME_RR_ARB_EN for
// round-robin grant; otherwise the lowest missing slot always wins.
module jtframe_rom_nslots
  import jtframe_rom_nslots_pkg::*;
#(
  parameter int                    SLOTS   = 4,
  parameter int                    AW      = 18,
  parameter logic [2*SLOTS-1:0]    DWSEL   = {SLOTS{2'd2}},
  parameter logic [22*SLOTS-1:0]   OFFSETS = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS-1:0]      slot_clr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic [21:0]           sdram_addr,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  data_dst,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  st_t                    state_q;
  logic                   req_q;
  logic [21:0]            addr_q;
  logic [SW-1:0]          sel_q;
  logic [SW-1:0]          win_d;
  logic [SLOTS-1:0]       hit;
  logic [SLOTS-1:0]       miss;
  logic [SLOTS-1:0][21:0] tag_live;
  logic                   fill_en;
  logic                   unused_ok;

  assign unused_ok = data_dst;
  assign fill_en   = (state_q == ST_WAIT) && data_rdy;
  assign miss      = slot_cs & ~hit;

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_slot
      assign tag_live[g] = map_addr(DWSEL[2*g+:2], OFFSETS[22*g+:22],
                                    32'(slot_addr[AW*g+:AW]));

      jtframe_rom_nslots_cache #(.DW(DWSEL[2*g+:2])) u_cache (
        .clk         (clk),
        .rst         (rst),
        .tag_i       (tag_live[g]),
        .byte_i      (slot_addr[AW*g]),
        .cs_i        (slot_cs[g]),
        .clr_i       (slot_clr[g]),
        .fill_i      (fill_en && (sel_q == SW'(g))),
        .fill_tag_i  (addr_q),
        .fill_data_i (data_read),
        .hit_o       (hit[g]),
        .ok_o        (slot_ok[g]),
        .dout_o      (slot_dout[32*g+:32])
      );
    end
  endgenerate

`ifdef JTFRAME_RR_ARB_EN
  logic [SW-1:0] rr_q;

  // scan from furthest to nearest so the slot right after rr_q wins
  always_comb begin
    int idx;
    win_d = '0;
    idx   = 0;
    for (int k = SLOTS; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % SLOTS;
      if (miss[idx]) win_d = SW'(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             rr_q <= SW'(SLOTS - 1);
    else if (state_q == ST_IDLE && |miss) rr_q <= win_d;
  end
`else
  always_comb begin
    win_d = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (miss[i]) win_d = SW'(i);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|miss) begin
          addr_q  <= tag_live[win_d];
          sel_q   <= win_d;
          req_q   <= 1'b1;
          state_q <= ST_REQ;
        end
        // data_rdy seen here belongs to another bank user and is dropped
        ST_REQ: if (sdram_ack) begin
          req_q   <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (data_rdy) state_q <= ST_IDLE;
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// Directed bench for jtframe_rom_nslots: SDRAM responder driven from one
// sequence, expected request addresses queued at stimulus time.
module tb_jtframe_rom_nslots;
  localparam int SLOTS = 4;
  localparam int AW    = 18;
  localparam logic [2*SLOTS-1:0]  DWSEL = {2'd2, 2'd1, 2'd0, 2'd2};
  localparam logic [22*SLOTS-1:0] OFFS  = {22'h30_0000, 22'h20_0000, 22'h10_0000, 22'h0};

  logic                clk, rst;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_cs, slot_clr, slot_ok;
  logic [SLOTS*32-1:0] slot_dout;
  logic [21:0]         sdram_addr;
  logic                sdram_req, sdram_ack, data_dst, data_rdy;
  logic [31:0]         data_read;

  int checks, failures;
  logic [21:0] expq[$];

  jtframe_rom_nslots #(.SLOTS(SLOTS), .AW(AW), .DWSEL(DWSEL), .OFFSETS(OFFS)) dut (
    .clk(clk), .rst(rst), .slot_addr(slot_addr), .slot_cs(slot_cs), .slot_clr(slot_clr),
    .slot_ok(slot_ok), .slot_dout(slot_dout), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  task automatic pop_exp(output logic [21:0] e);
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_pop observed=empty expected=entry");
      e = '0;
    end else e = expq.pop_front();
  endtask

  // wait for a request, compare its address, hold it a cycle, then ack
  task automatic do_req();
    int n;
    logic [21:0] e;
    n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(sdram_req), 64'd1);
    pop_exp(e);
    chk("sdram_addr", 64'(sdram_addr), 64'(e));
    tick();
    chk("req_hold", 64'(sdram_req), 64'd1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("req_drop_on_ack", 64'(sdram_req), 64'd0);
  endtask

  task automatic do_data(input logic [31:0] d);
    data_rdy  = 1'b1;
    data_read = d;
    tick();
    data_rdy  = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; slot_addr = '0; slot_cs = '0; slot_clr = '0;
    sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0; data_read = '0;
    tick(); tick();
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_ok", 64'(slot_ok), 64'd0);
    chk("rst_dout", 64'(slot_dout[63:0]), 64'd0);
    rst = 1'b0;
    tick();

    // 32b miss then hit
    set_addr(0, 18'h100); slot_cs = 4'b0001; expq.push_back(22'h200);
    #1 chk("miss_ok0", 64'(slot_ok[0]), 64'd0);
    tick();
    chk("req_edge_after_cs", 64'(sdram_req), 64'd1);
    do_req();
    do_data(32'hDEADBEEF);
    chk("fill_ok0", 64'(slot_ok[0]), 64'd1);
    chk("fill_dout0", 64'(slot_dout[31:0]), 64'hDEADBEEF);
    tick();
    chk("hit_ok0", 64'(slot_ok[0]), 64'd1);
    chk("hit_noreq", 64'(sdram_req), 64'd0);

    // 8b slot: one word serves both bytes
    slot_cs = 4'b0010; set_addr(1, 18'h3); expq.push_back(22'h10_0001);
    #1 chk("miss_ok1", 64'(slot_ok[1]), 64'd0);
    do_req();
    do_data(32'h0000AB12);
    chk("b3_ok1", 64'(slot_ok[1]), 64'd1);
    chk("b3_dout1", 64'(slot_dout[63:32]), 64'h000000AB);
    set_addr(1, 18'h2);
    #1 chk("b2_ok1", 64'(slot_ok[1]), 64'd1);
    chk("b2_dout1", 64'(slot_dout[63:32]), 64'h00000012);
    tick(); tick();
    chk("b2_noreq", 64'(sdram_req), 64'd0);
    slot_cs = '0;

    // arbitration from a fresh reset
    rst = 1'b1; tick();
    chk("rst2_ok", 64'(slot_ok), 64'd0);
    rst = 1'b0;
    set_addr(0, 18'h200); set_addr(1, 18'h10); set_addr(2, 18'h40); set_addr(3, 18'h80);
`ifdef JTFRAME_RR_ARB_EN
    expq.push_back(22'h00_0400); expq.push_back(22'h10_0008);
    expq.push_back(22'h20_0040); expq.push_back(22'h30_0100);
    slot_cs = 4'b1111;
    for (int s = 0; s < SLOTS; s++) begin
      do_req();
      do_data(32'h0000_0100 + 32'(s));
      chk("rr_ok", 64'(slot_ok[s]), 64'd1);
    end
`else
    expq.push_back(22'h00_0400);
    slot_cs = 4'b1111;
    for (int r = 0; r < 3; r++) begin
      do_req();
      do_data(32'h0000_0200 + 32'(r));
      chk("fp_ok0", 64'(slot_ok[0]), 64'd1);
      chk("fp_starved", 64'(slot_ok[3:1]), 64'd0);
      if (r < 2) begin
        set_addr(0, 18'(18'h201 + r));
        expq.push_back(22'(22'h402 + 2*r));
      end
    end
    slot_cs[0] = 1'b0;
    expq.push_back(22'h10_0008); expq.push_back(22'h20_0040); expq.push_back(22'h30_0100);
    for (int s = 1; s < SLOTS; s++) begin
      do_req();
      do_data(32'h0000_0100 + 32'(s));
      chk("fp_ok", 64'(slot_ok[s]), 64'd1);
    end
    slot_cs[0] = 1'b1;
`endif
    #1 chk("arb_all_ok", 64'(slot_ok), 64'hF);

    // address change while waiting for data
    slot_cs = 4'b0100; set_addr(2, 18'h50); expq.push_back(22'h20_0050);
    do_req();
    set_addr(2, 18'h51); expq.push_back(22'h20_0051);
    do_data(32'hFFFF7777);
    chk("chg_ok2", 64'(slot_ok[2]), 64'd0);
    do_req();
    do_data(32'hFFFF8888);
    chk("chg_refill_ok2", 64'(slot_ok[2]), 64'd1);
    chk("chg_dout2", 64'(slot_dout[95:64]), 64'h00008888);

    // clear on the fill cycle
    slot_cs = 4'b1000; set_addr(3, 18'h90); expq.push_back(22'h30_0120);
    do_req();
    slot_clr[3] = 1'b1;
    do_data(32'hAAAA5555);
    slot_clr[3] = 1'b0;
    chk("clr_ok3", 64'(slot_ok[3]), 64'd0);
    expq.push_back(22'h30_0120);
    do_req();
    do_data(32'h12345678);
    chk("clr_refill_ok3", 64'(slot_ok[3]), 64'd1);
    chk("clr_dout3", 64'(slot_dout[127:96]), 64'h12345678);

    // reset while waiting for data
    slot_cs = 4'b1001; set_addr(0, 18'h300); expq.push_back(22'h00_0600);
    #1 chk("pre_rst_ok3", 64'(slot_ok[3]), 64'd1);
    do_req();
    rst = 1'b1;
    #1 chk("async_rst_req", 64'(sdram_req), 64'd0);
    chk("async_rst_ok", 64'(slot_ok), 64'd0);
    chk("async_rst_addr", 64'(sdram_addr), 64'd0);
    slot_cs = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("sb_drained", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
